cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_cordic_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin front end sharing one pipelined CORDIC rotator
// among NREQ requesters; results return tagged to their originator.
module cordic #(
  parameter int DW   = 10,
  parameter int AW   = DW,
  parameter int ITER = DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic signed [AW-1:0] a_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [AW-1:0] a_o
);
  localparam int G  = 4;
  localparam int IW = DW + G + 2;
  localparam int ZW = AW + G + 1;
  localparam int SH = 32 - AW - G;
  localparam logic signed [IW-1:0] HI = IW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [IW-1:0] LO = -HI - IW'(1);
  localparam logic signed [ZW-1:0] QTR = ZW'(1 <<< (AW - 2 + G));
  localparam logic signed [17:0] KINV = 18'sd39797;

  // atan(2^-i)/pi scaled so that pi = 2^31
  function automatic int atan_c(input int i);
    int t;
    case (i)
      0:  t = 536870912;
      1:  t = 316933406;
      2:  t = 167458907;
      3:  t = 85004756;
      4:  t = 42667331;
      5:  t = 21354465;
      6:  t = 10679838;
      7:  t = 5340184;
      8:  t = 2670175;
      9:  t = 1335088;
      10: t = 667544;
      11: t = 333772;
      12: t = 166886;
      13: t = 83443;
      14: t = 41722;
      default: t = 20861 >>> (i - 15);
    endcase
    return (t + (1 <<< (SH - 1))) >>> SH;
  endfunction

  // pre-divide by the CORDIC gain so results come out unscaled
  function automatic logic signed [IW-1:0] gain(
    input logic signed [IW-1:0] v
  );
    return IW'(((IW+18)'(v) * (IW+18)'(KINV)
               + (IW+18)'(32768)) >>> 16);
  endfunction

  function automatic logic signed [DW-1:0] rnd_sat(
    input logic signed [IW-1:0] v
  );
    logic signed [IW-1:0] r;
    r = (v + IW'(1 <<< (G - 1))) >>> G;
    if (r > HI) return DW'(HI);
    if (r < LO) return DW'(LO);
    return DW'(r);
  endfunction

  logic signed [IW-1:0] xs, ys, xr, yr;
  logic signed [ZW-1:0] zs, zr;

  always_comb begin
    xs = IW'(x_i) <<< G;
    ys = IW'(y_i) <<< G;
    zs = ZW'(a_i) <<< G;
    xr = xs;
    yr = ys;
    zr = zs;
    unique case (1'b1)
      (a_i[AW-1 -: 2] == 2'b01): begin
        xr = -ys;
        yr = xs;
        zr = zs - QTR;
      end
      (a_i[AW-1 -: 2] == 2'b10): begin
        xr = ys;
        yr = -xs;
        zr = zs + QTR;
      end
      default: ;
    endcase
  end

  logic signed [IW-1:0] x_q [ITER+1];
  logic signed [IW-1:0] y_q [ITER+1];
  logic signed [ZW-1:0] z_q [ITER+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else if (en) begin
      x_q[0] <= gain(xr);
      y_q[0] <= gain(yr);
      z_q[0] <= zr;
      for (int i = 0; i < ITER; i++) begin
        if (z_q[i][ZW-1]) begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + ZW'(atan_c(i));
        end else begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - ZW'(atan_c(i));
        end
      end
    end
  end

  assign x_o = rnd_sat(x_q[ITER]);
  assign y_o = rnd_sat(y_q[ITER]);
  assign a_o = AW'((z_q[ITER] + ZW'(1 <<< (G - 1))) >>> G);
endmodule

module cordic_sched #(
  parameter  int NREQ = 4,
  parameter  int DW   = 10,
  parameter  int AW   = DW,
  parameter  int ITER = DW,
  localparam int LAT  = ITER + 1,
  localparam int CW   = $clog2(LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  input  logic [NREQ*AW-1:0] req_a,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_x,
  output logic [DW-1:0]      rsp_y,
  output logic [AW-1:0]      rsp_arem,
  output logic [CW-1:0]      inflight
);
  localparam int TW = $clog2(NREQ);

  logic [TW-1:0]  tag_q [LAT];
  logic [LAT-1:0] vld_q;
  logic [TW-1:0]  ptr_q, ptr_d, gnt, out_tag;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           gnt_ok, adv, acc, out_v;
  logic [DW-1:0]  in_x, in_y;
  logic [AW-1:0]  in_a;

  assign out_v   = vld_q[LAT-1];
  assign out_tag = tag_q[LAT-1];
  // only an unaccepted result at the head freezes the pipe
  assign adv     = !(out_v && !rsp_ready[out_tag]);

  always_comb begin
    gnt_ok = 1'b0;
    gnt    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_ok && req_valid[j[TW-1:0]]) begin
        gnt_ok = 1'b1;
        gnt    = TW'(j);
      end
    end
  end

  always_comb begin
    acc       = rst_n && adv && gnt_ok;
    req_ready = acc ? (NREQ'(1) << gnt) : '0;
    in_x      = acc ? req_x[int'(gnt)*DW +: DW] : '0;
    in_y      = acc ? req_y[int'(gnt)*DW +: DW] : '0;
    in_a      = acc ? req_a[int'(gnt)*AW +: AW] : '0;
    ptr_d     = (gnt == TW'(NREQ - 1)) ? '0 : gnt + TW'(1);
    cnt_d     = cnt_q + CW'(acc) - CW'(out_v);
    rsp_valid = (rst_n && out_v) ? (NREQ'(1) << out_tag) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else if (adv) begin
      vld_q    <= {vld_q[LAT-2:0], acc};
      tag_q[0] <= acc ? gnt : '0;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      cnt_q    <= cnt_d;
      if (acc) ptr_q <= ptr_d;
    end
  end

  assign inflight = cnt_q;

  cordic #(
    .DW  (DW),
    .AW  (AW),
    .ITER(ITER)
  ) u_cordic (
    .clk(clk),
    .rst(!rst_n),
    .en (adv),
    .x_i(in_x),
    .y_i(in_y),
    .a_i(in_a),
    .x_o(rsp_x),
    .y_o(rsp_y),
    .a_o(rsp_arem)
  );
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed scenarios plus random traffic, checked by a
// queue scoreboard against an ideal floating-point rotation model.
module tb_cordic_sched;
  localparam int NREQ = 4;
  localparam int DW   = 10;
  localparam int AW   = 10;
  localparam int ITER = 10;
  localparam int LAT  = ITER + 1;
  localparam int CW   = $clog2(LAT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0] req_x, req_y;
  logic [NREQ*AW-1:0] req_a;
  logic [DW-1:0]      rsp_x, rsp_y;
  logic [AW-1:0]      rsp_arem;
  logic [CW-1:0]      inflight;

  typedef struct {
    int id;
    int x;
    int y;
    int a;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int errors = 0;
  int rr = 0;
  bit prev_stall = 1'b0;
  logic [NREQ-1:0] pv;
  logic [DW-1:0] px, py;
  logic [AW-1:0] pa;

  always #5 clk = ~clk;

  cordic_sched #(
    .NREQ(NREQ),
    .DW  (DW),
    .AW  (AW),
    .ITER(ITER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_a    (req_a),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_x    (rsp_x),
    .rsp_y    (rsp_y),
    .rsp_arem (rsp_arem),
    .inflight (inflight)
  );

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int s10(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic void ref_rot(input txn_t t, output real ex,
                                  output real ey);
    real th;
    th = t.a * 3.14159265358979 / 512.0;
    ex = t.x * $cos(th) - t.y * $sin(th);
    ey = t.x * $sin(th) + t.y * $cos(th);
  endfunction

  task automatic mon_step();
    bit stall;
    bit found;
    logic [NREQ-1:0] exp_rdy;
    int g;
    txn_t t;
    real ex, ey;
    if (!rst_n) begin
      sb.delete();
      rr = 0;
      prev_stall = 1'b0;
      return;
    end
    stall = (rsp_valid != 0) && ((rsp_valid & rsp_ready) == 0);
    chk(int'(inflight) == sb.size(), "inflight", inflight, sb.size());
    if (prev_stall)
      chk({rsp_valid, rsp_x, rsp_y, rsp_arem} == {pv, px, py, pa},
          "stall_hold", {rsp_valid, rsp_x, rsp_y, rsp_arem},
          {pv, px, py, pa});
    exp_rdy = '0;
    found = 1'b0;
    if (!stall)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (rr + k) % NREQ;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          exp_rdy[j] = 1'b1;
        end
      end
    chk(req_ready == exp_rdy, "grant", req_ready, exp_rdy);
    if (rsp_valid != 0) begin
      chk(sb.size() != 0, "rsp_expected", rsp_valid, 0);
      if (sb.size() != 0) begin
        t = sb[0];
        chk(rsp_valid == (NREQ'(1) << t.id), "rsp_tag",
            rsp_valid, 1 << t.id);
        if (!stall) begin
          t = sb.pop_front();
          ref_rot(t, ex, ey);
          chk(rabs(s10(rsp_x) - ex) <= 3.0, "rsp_x",
              s10(rsp_x), $rtoi(ex));
          chk(rabs(s10(rsp_y) - ey) <= 3.0, "rsp_y",
              s10(rsp_y), $rtoi(ey));
          chk(s10(rsp_arem) >= -2 && s10(rsp_arem) <= 2, "rsp_arem",
              s10(rsp_arem), 0);
        end
      end
    end
    if ((req_valid & req_ready) != 0) begin
      g = 0;
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
      t.id = g;
      t.x  = s10(req_x[g*DW +: DW]);
      t.y  = s10(req_y[g*DW +: DW]);
      t.a  = s10(req_a[g*AW +: AW]);
      sb.push_back(t);
      rr = (g + 1) % NREQ;
    end
    prev_stall = stall;
    pv = rsp_valid;
    px = rsp_x;
    py = rsp_y;
    pa = rsp_arem;
  endtask

  always @(negedge clk) mon_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input int x, input int y,
                        input int a);
    req_x[i*DW +: DW] = DW'(x);
    req_y[i*DW +: DW] = DW'(y);
    req_a[i*AW +: AW] = AW'(a);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_op(i, int'($urandom_range(0, 640)) - 320,
             int'($urandom_range(0, 640)) - 320, int'($urandom));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || inflight != 0) && n < 4 * LAT) begin
      tick();
      n++;
    end
    chk(sb.size() == 0 && inflight == 0, nm, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    logic [DW-1:0] hx, hy;
    logic [AW-1:0] ha;
    logic [CW-1:0] hf;
    req_valid = '1;
    rsp_ready = '1;
    req_x = '0;
    req_y = '0;
    req_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(rsp_valid == 0, "rst_rsp_valid", rsp_valid, 0);
    chk(req_ready == 0, "rst_req_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk(inflight == 0, "rst_inflight", inflight, 0);

    // single pi/4 rotation from requester 1
    do_reset();
    set_op(1, 'h100, 0, 'h080);
    req_valid = 4'b0010;
    @(negedge clk);
    chk(req_ready == 4'b0010, "pi4_ready", req_ready, 2);
    tick();
    req_valid = '0;
    lat = 0;
    for (int k = 1; k <= 3 * LAT && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) lat = k;
    end
    chk(lat == LAT, "pi4_latency", lat, LAT);
    chk(rsp_valid == 4'b0010, "pi4_valid", rsp_valid, 2);
    chk(s10(rsp_x) >= 178 && s10(rsp_x) <= 184, "pi4_x", s10(rsp_x), 181);
    chk(s10(rsp_y) >= 178 && s10(rsp_y) <= 184, "pi4_y", s10(rsp_y), 181);
    chk(s10(rsp_arem) >= -2 && s10(rsp_arem) <= 2, "pi4_arem",
        s10(rsp_arem), 0);

    // all four requesting: round-robin grants and ordered returns
    do_reset();
    rand_ops();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(req_ready == (NREQ'(1) << (i % NREQ)), "rr_grant",
          req_ready, 1 << (i % NREQ));
      tick();
    end
    req_valid = '0;
    lat = 0;
    for (int k = 0; k < 3 * LAT && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) lat = 1;
    end
    for (int i = 0; i < 8; i++) begin
      chk(rsp_valid == (NREQ'(1) << (i % NREQ)), "rr_rsp_order",
          rsp_valid, 1 << (i % NREQ));
      if (i < 7) @(negedge clk);
    end
    drain("rr_drain");

    // head-of-line stall on requester 2
    do_reset();
    rand_ops();
    rsp_ready = 4'b1011;
    req_valid = '1;
    lat = 0;
    for (int k = 0; k < 4 * LAT && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid == 4'b0100) lat = 1;
    end
    chk(lat == 1, "stall_reached", lat, 1);
    hx = rsp_x;
    hy = rsp_y;
    ha = rsp_arem;
    hf = inflight;
    chk(req_ready == 0, "stall_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk(rsp_valid == 4'b0100, "stall_valid", rsp_valid, 4);
      chk({rsp_x, rsp_y, rsp_arem} == {hx, hy, ha}, "stall_data",
          {rsp_x, rsp_y, rsp_arem}, {hx, hy, ha});
      chk(inflight == hf, "stall_inflight", inflight, hf);
      chk(req_ready == 0, "stall_ready", req_ready, 0);
    end
    tick();
    rsp_ready = '1;
    req_valid = '0;
    drain("stall_drain");

    // reset while six results are in flight
    do_reset();
    rand_ops();
    req_valid = '1;
    repeat (6) tick();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk(inflight == 6, "midrst_pre", inflight, 6);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk(inflight == 0, "midrst_inflight", inflight, 0);
    cnt = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) cnt++;
    end
    chk(cnt == 0, "midrst_no_rsp", cnt, 0);

    // fill the pipe with nothing consumed
    do_reset();
    rand_ops();
    rsp_ready = '0;
    req_valid = '1;
    repeat (20) tick();
    @(negedge clk);
    chk(inflight == LAT, "full_inflight", inflight, LAT);
    chk(req_ready == 0, "full_ready", req_ready, 0);
    chk(rsp_valid == 4'b0001, "full_head", rsp_valid, 1);
    tick();
    rsp_ready = '1;
    req_valid = '0;
    drain("full_drain");

    // random traffic with random back-pressure
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      rand_ops();
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        rsp_ready[i] = ($urandom_range(0, 4) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
